// File: rtl/barrel_pkg.sv
// Shared definitions for the rotation datapath: FSM state encoding and
// width-generic single-bit rotate helpers used by both barrel stages.
package barrel_pkg;

  // Widest word the rotate helpers handle; callers cast to and from this.
  localparam int unsigned MAX_W = 64;

  // FSM state encoding for the serial rotate engines.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_ROTATE = 2'd1;
  localparam state_t ST_HOLD   = 2'd2;

  // Rotate the low w bits of v right by one; bits above w come back as zero.
  function automatic logic [MAX_W-1:0] rotr1(input logic [MAX_W-1:0] v,
                                             input int unsigned w);
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] wrap;
    mask = (w >= MAX_W) ? {MAX_W{1'b1}} : ((64'd1 << w) - 64'd1);
    wrap = {{(MAX_W-1){1'b0}}, v[0]} << (w - 32'd1);
    rotr1 = ((v & mask) >> 1) | wrap;
  endfunction

  // Rotate the low w bits of v left by one; bits above w come back as zero.
  function automatic logic [MAX_W-1:0] rotl1(input logic [MAX_W-1:0] v,
                                             input int unsigned w);
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] wrap;
    mask = (w >= MAX_W) ? {MAX_W{1'b1}} : ((64'd1 << w) - 64'd1);
    wrap = {{(MAX_W-1){1'b0}}, v[w-32'd1]};
    rotl1 = ((v << 1) | wrap) & mask;
  endfunction

endpackage

// File: rtl/barrel_unrotate_serial.sv
// Iterative rotate-right engine: undoes a left rotation one bit per clock,
// then holds the recovered word on a valid/ready output.
module barrel_unrotate_serial
  import barrel_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amount,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  state_t           state_r;
  logic [WIDTH-1:0] data_r;
  logic [SHW-1:0]   count_r;
  logic             accept_s;
  logic [SHW-1:0]   amount_mod_s;

  // Reduce the requested amount mod WIDTH so non-power-of-two widths wrap correctly.
  always_comb begin
    amount_mod_s = SHW'(32'(in_amount) % 32'(WIDTH));
  end

  // Handshake decode from the current state; HOLD can drain and accept in one cycle.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        in_ready = 1'b1;
      end
      ST_ROTATE: begin
        busy = 1'b1;
      end
      ST_HOLD: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  assign accept_s = in_valid && in_ready;
  assign out_data = data_r;

  // FSM, down-counter and data register: load on accept, rotate right once per cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      data_r  <= {WIDTH{1'b0}};
      count_r <= {SHW{1'b0}};
    end else if (accept_s) begin
      data_r  <= in_data;
      count_r <= amount_mod_s;
      state_r <= (amount_mod_s == {SHW{1'b0}}) ? ST_HOLD : ST_ROTATE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_r <= ST_IDLE;
        end
        ST_ROTATE: begin
          data_r  <= WIDTH'(rotr1(MAX_W'(data_r), WIDTH));
          count_r <= count_r - SHW'(1);
          // A zero count here cannot occur legally; treat it as done rather than spin.
          if (count_r <= SHW'(1)) begin
            state_r <= ST_HOLD;
          end else begin
            state_r <= ST_ROTATE;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_HOLD;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/barrel_unrotate_serial.md
# barrel_unrotate_serial

Iterative rotate-right engine: the inverse of the barrel shift register's rotate-left stage. It accepts a rotated word plus the rotation amount through a valid/ready handshake. It undoes the rotation by rotating right one bit per clock, then holds the recovered word on a valid/ready output until the consumer takes it. It sits on the receive side of the rotation datapath, downstream of the left-rotating barrel stage.

## Interface
- WIDTH, default 4: data word width; must be ≥ 2.
- SHW, default $clog2(WIDTH) = 2: width of the rotation amount.

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  reset, synchronous, active-high.
- in_valid  in  1  producer offers in_data/in_amount.
- in_ready  out  1  block can accept a word this cycle.
- in_data  in  WIDTH  rotated word.
- in_amount  in  SHW  number of positions to rotate right, 0..WIDTH-1 (values ≥ WIDTH are masked mod WIDTH by the wrap rule below).
- out_valid  out  1  out_data holds a recovered word.
- out_ready  in  1  consumer accepts out_data.
- out_data  out  WIDTH  recovered word.
- busy  out  1  high in ROTATE state.

## Operation
- State machine, three states:
  - IDLE: in_ready = 1, out_valid = 0.
  - ROTATE: in_ready = 0, out_valid = 0, busy = 1.
  - HOLD: out_valid = 1; in_ready = out_ready.
- Accept = in_valid && in_ready. On accept:
  - capture in_data into the data register;
  - load the down-counter with in_amount;
  - next state is HOLD if in_amount == 0, else ROTATE.
- ROTATE, each cycle:
  - data <= {data[0], data[WIDTH-1:1]} (rotate right by 1);
  - count <= count − 1;
  - when count == 1, the next state is HOLD.
- HOLD:
  - out_data and out_valid stay stable until out_ready is high.
  - On out_ready with no simultaneous accept, the next state is IDLE.
  - On out_ready with a simultaneous accept (in_valid high), the new word loads with the same rules as from IDLE. This allows back-to-back operation with no idle bubble.
- Amount wrap: the counter is SHW bits wide. For non-power-of-two WIDTH, the amount is reduced mod WIDTH at capture. The result always equals a rotate-right by (in_amount mod WIDTH).
- The input is ignored outside IDLE/HOLD-drain: in_valid high with in_ready low has no effect; the producer must hold its data.
- out_data reflects the data register at all times. It is architecturally meaningful only while out_valid is high.

## Timing
- Reset values: state = IDLE, in_ready = 1, out_valid = 0, busy = 0, out_data = 0, count = 0.
- Reset mid-ROTATE or mid-HOLD aborts immediately. The next cycle is IDLE with all reset values, and no output is produced for the aborted word.
- Latency: out_valid rises after the edge at accept + in_amount cycles.
  - Amount 0: valid in the cycle after accept.
  - Amount 3: valid 3 cycles after accept.
- Throughput: one word per (in_amount + 1) cycles, with zero-cycle drain/accept overlap in HOLD.
- Backpressure: there is no bound on out_ready low; state is held indefinitely.

## Structure
- Shared package barrel_pkg holds:
  - the state typedef (IDLE, ROTATE, HOLD);
  - the rotr1 function (single-bit rotate right, WIDTH-generic);
  - the matching rotl1, shared with the rotate-left stage.
- No sub-module: FSM, counter and data register live in one module.

## Test plan
- in_data 4'b0110, amount 1, out_ready 1 → out_data 4'b0011, out_valid one cycle after accept.
- in_data 4'b1011, amount 0 → out_data 4'b1011 the cycle after accept; busy never asserts.
- in_data 4'b0001, amount 3 → busy high 3 cycles, then out_data 4'b0010; in_data 4'b1100, amount 2 → 4'b0011.
- Backpressure: amount 2, out_ready low for 5 cycles → out_valid/out_data stable; in_ready low until out_ready rises. Then drain and a simultaneous new accept occur in the same cycle, with no IDLE cycle between.
- Reset asserted during ROTATE (amount 3, after 1 rotation) → next cycle IDLE, out_valid 0, out_data 0, in_ready 1; a following word is processed normally.
- Round trip: for every 4-bit value and amounts 0..3, rotate left by the amount then feed this block → out_data equals the original value.
